// File: rtl/seven_seg_calc_display.sv
// ---------------------------------------------------------------------------
// seven_seg_calc_display
//
// Multi-digit calculator display for the Basys3 seven-segment panel. Two
// operands come from the slide switches. The block shows A+B, A-B, A*B or the
// raw operands, scanned one digit at a time. The result is captured once per
// frame so that the displayed value never changes part way through a scan.
//
// Parameters:
//   DIVIDE_BY     - scan tick period is 2^DIVIDE_BY clk cycles
//   NUM_DIGITS    - digits scanned (even, NUM_DIGITS*4 >= 2*OPERAND_WIDTH)
//   OPERAND_WIDTH - width W of each operand
//
// Ports:
//   clk  in  1           board clock
//   btnC in  1           synchronous active-high reset
//   sw   in  2W          {B, A}, asynchronous to clk
//   mode in  2           00 A+B, 01 A-B, 10 raw A/B, 11 A*B, asynchronous
//   an   out NUM_DIGITS  digit anodes, active-low
//   seg  out 7           segments {g,f,e,d,c,b,a}, active-low
//   dp   out 1           decimal point, active-low (negative A-B marker)
//
// Build option:
//   SEVEN_SEG_LZB_EN - when defined, leading zeros are blanked in the
//                      arithmetic modes (digit 0 and raw mode never blank).
// ---------------------------------------------------------------------------
module seven_seg_calc_display #(
    parameter int DIVIDE_BY     = 17,
    parameter int NUM_DIGITS    = 4,
    parameter int OPERAND_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       btnC,
    input  logic [2*OPERAND_WIDTH-1:0] sw,
    input  logic [1:0]                 mode,
    output logic [NUM_DIGITS-1:0]      an,
    output logic [6:0]                 seg,
    output logic                       dp
);

    localparam int W      = OPERAND_WIDTH;
    localparam int RES_W  = 4 * NUM_DIGITS;
    localparam int HALF_W = RES_W / 2;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIG_W-1:0]      LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
    localparam logic [DIG_W-1:0]      DIGIT_INC  = DIG_W'(1);
    localparam logic [NUM_DIGITS-1:0] DIGIT_ONE  = NUM_DIGITS'(1);
    localparam logic [DIVIDE_BY-1:0]  PRESC_INC  = DIVIDE_BY'(1);

    // Standard active-low hex font, {g,f,e,d,c,b,a}
    function automatic logic [6:0] hexSeg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            4'hF:    pattern = 7'h0E;
            default: pattern = 7'h7F;
        endcase
        return pattern;
    endfunction

    logic [2*W-1:0]        swMeta_r, swSync_r;
    logic [1:0]            modeMeta_r, modeSync_r;
    logic [DIVIDE_BY-1:0]  prescale_r;
    logic [DIG_W-1:0]      digit_r;
    logic                  started_r;
    logic [RES_W-1:0]      result_r;
    logic                  neg_r;
    logic [1:0]            capMode_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic [6:0]            seg_r;
    logic                  dp_r;

    logic                  tick_s;
    logic                  frameEnd_s;
    logic [W-1:0]          opA_s, opB_s;
    logic [RES_W-1:0]      aExt_s, bExt_s;
    logic [RES_W-1:0]      calc_s;
    logic                  negCalc_s;
    logic [DIG_W-1:0]      digitNext_s;
    logic [RES_W-1:0]      resultNext_s;
    logic                  negNext_s;
    logic [1:0]            modeNext_s;
    logic [3:0]            nibble_s;
    logic                  blank_s;
    logic [NUM_DIGITS-1:0] anNext_s;
    logic [6:0]            segNext_s;
    logic                  dpNext_s;

    assign tick_s = &prescale_r;
    // The first tick after reset also starts a frame, so digit 0 with a fresh
    // result is the first thing ever shown.
    assign frameEnd_s = tick_s && ((digit_r == LAST_DIGIT) || !started_r);

    // Two-flop synchronisers for the switch and mode inputs
    always_ff @(posedge clk) begin
        if (btnC) begin
            swMeta_r   <= {(2*W){1'b0}};
            swSync_r   <= {(2*W){1'b0}};
            modeMeta_r <= 2'b00;
            modeSync_r <= 2'b00;
        end else begin
            swMeta_r   <= sw;
            swSync_r   <= swMeta_r;
            modeMeta_r <= mode;
            modeSync_r <= modeMeta_r;
        end
    end

    // Free-running scan prescaler; wraps to zero right after the tick
    always_ff @(posedge clk) begin
        if (btnC) begin
            prescale_r <= {DIVIDE_BY{1'b0}};
        end else begin
            prescale_r <= prescale_r + PRESC_INC;
        end
    end

    // Arithmetic unit on the synchronised operands
    always_comb begin
        opA_s     = swSync_r[W-1:0];
        opB_s     = swSync_r[2*W-1:W];
        aExt_s    = {{(RES_W-W){1'b0}}, opA_s};
        bExt_s    = {{(RES_W-W){1'b0}}, opB_s};
        negCalc_s = (modeSync_r == 2'b01) && (opB_s > opA_s);
        case (modeSync_r)
            2'b00:   calc_s = aExt_s + bExt_s;
            2'b01:   calc_s = aExt_s - bExt_s;
            // Product of two W-bit values fits in 2W <= RES_W bits
            2'b11:   calc_s = aExt_s * bExt_s;
            // Raw: A in the low half of the digits, B in the high half
            2'b10:   calc_s = aExt_s | (bExt_s << HALF_W);
            default: calc_s = {RES_W{1'b0}};
        endcase
    end

    // Next scan position and the value that slot will show
    always_comb begin
        digitNext_s  = digit_r;
        resultNext_s = result_r;
        negNext_s    = neg_r;
        modeNext_s   = capMode_r;
        if (frameEnd_s) begin
            digitNext_s  = {DIG_W{1'b0}};
            resultNext_s = calc_s;
            negNext_s    = negCalc_s;
            modeNext_s   = modeSync_r;
        end else if (tick_s) begin
            digitNext_s  = digit_r + DIGIT_INC;
        end else begin
            digitNext_s  = digit_r;
        end
    end

    // Segment, anode and decimal-point values for the next slot
    always_comb begin
        nibble_s  = resultNext_s[{digitNext_s, 2'b00} +: 4];
`ifdef SEVEN_SEG_LZB_EN
        // Blank when this nibble and everything above it are zero
        blank_s   = (digitNext_s != {DIG_W{1'b0}}) &&
                    (modeNext_s != 2'b10) &&
                    ((resultNext_s >> {digitNext_s, 2'b00}) == {RES_W{1'b0}});
`else
        blank_s   = 1'b0;
`endif
        if (blank_s) begin
            anNext_s  = {NUM_DIGITS{1'b1}};
            segNext_s = 7'h7F;
        end else begin
            anNext_s  = ~(DIGIT_ONE << digitNext_s);
            segNext_s = hexSeg(nibble_s);
        end
        dpNext_s = !((digitNext_s == {DIG_W{1'b0}}) &&
                     (modeNext_s == 2'b01) && negNext_s);
    end

    // Digit scanner and per-frame result capture
    always_ff @(posedge clk) begin
        if (btnC) begin
            digit_r   <= {DIG_W{1'b0}};
            started_r <= 1'b0;
            result_r  <= {RES_W{1'b0}};
            neg_r     <= 1'b0;
            capMode_r <= 2'b00;
        end else begin
            digit_r   <= digitNext_s;
            result_r  <= resultNext_s;
            neg_r     <= negNext_s;
            capMode_r <= modeNext_s;
            if (tick_s) begin
                started_r <= 1'b1;
            end else begin
                started_r <= started_r;
            end
        end
    end

    // Registered display outputs, refreshed once per scan tick
    always_ff @(posedge clk) begin
        if (btnC) begin
            an_r  <= {NUM_DIGITS{1'b1}};
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
        end else if (tick_s) begin
            an_r  <= anNext_s;
            seg_r <= segNext_s;
            dp_r  <= dpNext_s;
        end else begin
            an_r  <= an_r;
            seg_r <= seg_r;
            dp_r  <= dp_r;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule
